// File: rtl/midi_uart_tx_pkg.sv
// Shared constants and types for the MIDI/UART transmit path: default bit period,
// TX FSM state encodings and the debug snapshot exposed by the transmitter.
package midi_uart_tx_pkg;

  // 50 MHz system clock / 31250 baud MIDI line
  localparam int MIDI_CLKS_PER_BIT = 1600;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  typedef struct packed {
    logic [1:0] state;
    logic [2:0] bit_cnt;
    logic       stop_idx;
    logic       fifo_full;
    logic       fifo_empty;
  } tx_dbg_t;

endpackage

// File: rtl/midi_uart_tx_byte_fifo.sv
// Small synchronous FIFO with first-word-fall-through output; shared by the TX path
// and intended for reuse as the RX byte buffer.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty_o = (r_wr_ptr == r_rd_ptr);
  assign w_push  = wr_en_i && !full_o;
  assign w_pop   = rd_en_i && !empty_o;

  assign rd_data_o = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/midi_uart_tx.sv
// MIDI/UART transmitter: 8N1 (or 8N2) frames, LSB first, idle-high line, bytes
// buffered in a FIFO and sent back-to-back with no idle gap between frames.
module midi_uart_tx
  import midi_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = MIDI_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       txData_o,
  output logic       busy_o,
  output tx_dbg_t    dbg_o
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  logic [1:0]    r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit_cnt;
  logic          r_stop_idx;
  logic [7:0]    r_shift;
  logic          r_tx;

  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic [7:0] w_fifo_data;
  logic       w_bit_end;
  logic       w_stop_end;

  // Handshake: a byte transfers on every rising edge where valid_i && ready_o.
  // ready_o depends only on FIFO fullness, so a pop on the same edge as a full
  // FIFO never opens a slot for that edge's push.
  assign ready_o = !w_full;
  assign w_push  = valid_i && !w_full;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i     (clk_i),
    .nrst_i    (nrst_i),
    .wr_en_i   (w_push),
    .wr_data_i (data_i),
    .rd_en_i   (w_pop),
    .rd_data_o (w_fifo_data),
    .full_o    (w_full),
    .empty_o   (w_empty)
  );

  assign w_bit_end  = (r_baud == BAUD_LAST);
  assign w_stop_end = (r_state == TX_STOP) && w_bit_end && (r_stop_idx == STOP_LAST);
  // Pop from idle, or at the end of a stop period so the next start bit follows directly
  assign w_pop      = !w_empty && ((r_state == TX_IDLE) || w_stop_end);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_state    <= TX_IDLE;
      r_baud     <= '0;
      r_bit_cnt  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_state)
        TX_IDLE: begin
          r_baud <= '0;
          r_tx   <= 1'b1;
          if (w_pop) begin
            r_shift <= w_fifo_data;
            r_state <= TX_START;
            r_tx    <= 1'b0;
          end
        end
        TX_START: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_state <= TX_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        TX_DATA: begin
          if (w_bit_end) begin
            r_baud    <= '0;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state    <= TX_STOP;
              r_stop_idx <= 1'b0;
              r_tx       <= 1'b1;
            end else begin
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        TX_STOP: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_stop_idx == STOP_LAST) begin
              r_stop_idx <= 1'b0;
              if (w_pop) begin
                r_shift <= w_fifo_data;
                r_state <= TX_START;
                r_tx    <= 1'b0;
              end else begin
                r_state <= TX_IDLE;
                r_tx    <= 1'b1;
              end
            end else begin
              r_stop_idx <= r_stop_idx + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= TX_IDLE;
          r_baud  <= '0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign txData_o = r_tx;
  assign busy_o   = (r_state != TX_IDLE) || !w_empty;

  assign dbg_o.state      = r_state;
  assign dbg_o.bit_cnt    = r_bit_cnt;
  assign dbg_o.stop_idx   = r_stop_idx;
  assign dbg_o.fifo_full  = w_full;
  assign dbg_o.fifo_empty = w_empty;

endmodule

// File: tb/tb_midi_uart_tx.sv
// Directed bench for midi_uart_tx: one 1-stop-bit instance and one 2-stop-bit instance,
// serial frames decoded cycle-by-cycle and compared against hand-computed bytes.
module tb_midi_uart_tx;
  import midi_uart_tx_pkg::*;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       nrst;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       ready_a, ready_b;
  logic       tx_a, tx_b;
  logic       busy_a, busy_b;
  tx_dbg_t    dbg_a, dbg_b;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  midi_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk_i(clk), .nrst_i(nrst), .data_i(data_a), .valid_i(valid_a),
    .ready_o(ready_a), .txData_o(tx_a), .busy_o(busy_a), .dbg_o(dbg_a)
  );

  midi_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk_i(clk), .nrst_i(nrst), .data_i(data_b), .valid_i(valid_b),
    .ready_o(ready_b), .txData_o(tx_b), .busy_o(busy_b), .dbg_o(dbg_b)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rx_line(input int sel);
    return (sel != 0) ? tx_b : tx_a;
  endfunction

  task automatic wait_idle(input int sel);
    int guard = 0;
    while (((sel != 0) ? busy_b : busy_a) !== 1'b0 && guard < 3000) begin
      tick();
      guard++;
    end
    n_tests++;
    if (guard >= 3000) begin
      n_fail++;
      $display("FAIL wait_idle%0d: busy still %b, expected 0", sel, (sel != 0) ? busy_b : busy_a);
    end
  endtask

  task automatic push_byte(input int sel, input logic [7:0] d);
    int guard = 0;
    if (sel != 0) begin
      data_b = d; valid_b = 1'b1;
      while (ready_b !== 1'b1 && guard < 3000) begin tick(); guard++; end
    end else begin
      data_a = d; valid_a = 1'b1;
      while (ready_a !== 1'b1 && guard < 3000) begin tick(); guard++; end
    end
    n_tests++;
    if (guard >= 3000) begin
      n_fail++;
      $display("FAIL push_timeout: ready stayed 0, expected 1");
    end
    tick();
    if (sel != 0) valid_b = 1'b0; else valid_a = 1'b0;
  endtask

  // Decodes one frame, checking every cycle of every bit for correct level and constancy
  task automatic rx_frame(input int sel, input int stop_bits, output logic [7:0] b,
                          output int gap, output bit ok);
    logic first, v;
    int nbits;
    ok = 1'b1; gap = 0; b = 8'h00; first = 1'b0;
    tick();
    while (rx_line(sel) !== 1'b0 && gap < 3000) begin gap++; tick(); end
    if (gap >= 3000) begin ok = 1'b0; return; end
    nbits = 9 + stop_bits;
    for (int bi = 0; bi < nbits; bi++) begin
      for (int c = 0; c < CPB; c++) begin
        if (!(bi == 0 && c == 0)) tick();
        v = rx_line(sel);
        if (c == 0) first = v;
        else if (v !== first) ok = 1'b0;
        if (bi == 0 && v !== 1'b0) ok = 1'b0;
        if (bi >= 9 && v !== 1'b1) ok = 1'b0;
        if (bi >= 1 && bi <= 8 && c == 0) b[bi-1] = v;
      end
    end
  endtask

  task automatic rx_check(input int sel, input int stop_bits, input int n, input string name);
    logic [7:0] b, exp;
    int gap;
    bit ok;
    for (int i = 0; i < n; i++) begin
      rx_frame(sel, stop_bits, b, gap, ok);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_tests++;
      if (!ok || b !== exp) begin
        n_fail++;
        $display("FAIL %s_frame%0d: got %02h (frame_ok=%0d), expected %02h", name, i, b, ok, exp);
      end
      if (i > 0) begin
        n_tests++;
        if (gap != 0) begin
          n_fail++;
          $display("FAIL %s_gap%0d: idle gap %0d cycles, expected 0", name, i, gap);
        end
      end
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0;
    data_a = 8'h00; data_b = 8'h00;
    repeat (3) tick();
    n_tests++;
    if (tx_a !== 1'b1 || tx_b !== 1'b1) begin
      n_fail++; $display("FAIL reset_line: got %b/%b, expected 1/1", tx_a, tx_b);
    end
    n_tests++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b/%b, expected 0/0", busy_a, busy_b);
    end
    n_tests++;
    if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b/%b, expected 1/1", ready_a, ready_b);
    end
    n_tests++;
    if (dbg_a.state !== TX_IDLE || dbg_a.bit_cnt !== 3'd0) begin
      n_fail++; $display("FAIL reset_fsm: state %0d bit_cnt %0d, expected 0 0", dbg_a.state, dbg_a.bit_cnt);
    end
    nrst = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single_byte();
    logic [7:0] d;
    logic exp_line, exp_busy;
    d = 8'hA5;
    push_byte(0, d);
    n_tests++;
    if (tx_a !== 1'b1 || busy_a !== 1'b1) begin
      n_fail++; $display("FAIL single_accept: line %b busy %b, expected 1 1", tx_a, busy_a);
    end
    for (int k = 1; k <= 41; k++) begin
      tick();
      if (k <= 4)       exp_line = 1'b0;
      else if (k <= 36) exp_line = d[(k - 5) / 4];
      else              exp_line = 1'b1;
      exp_busy = (k <= 40);
      n_tests++;
      if (tx_a !== exp_line || busy_a !== exp_busy) begin
        n_fail++;
        $display("FAIL single_cycle%0d: line %b busy %b, expected line %b busy %b",
                 k, tx_a, busy_a, exp_line, exp_busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    wait_idle(0);
    exp_q = {8'h00, 8'hFF, 8'h55};
    fork
      begin
        push_byte(0, 8'h00);
        push_byte(0, 8'hFF);
        push_byte(0, 8'h55);
      end
      rx_check(0, 1, 3, "b2b");
    join
    tick();
    n_tests++;
    if (busy_a !== 1'b0) begin
      n_fail++; $display("FAIL b2b_busy_end: got %b, expected 0", busy_a);
    end
  endtask

  task automatic test_hold_valid();
    logic [7:0] vec [6];
    int accepted, drop_at, guard;
    vec = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    wait_idle(0);
    exp_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    accepted = 0; drop_at = -1;
    fork
      begin
        valid_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
          data_a = vec[i];
          guard = 0;
          while (ready_a !== 1'b1 && guard < 3000) begin
            if (drop_at < 0) drop_at = accepted;
            tick(); guard++;
          end
          tick();
          accepted++;
        end
        valid_a = 1'b0;
      end
      rx_check(0, 1, 6, "hold");
    join
    n_tests++;
    if (drop_at != 5) begin
      n_fail++; $display("FAIL hold_ready_drop: dropped after %0d bytes, expected 5", drop_at);
    end
    tick();
    n_tests++;
    if (busy_a !== 1'b0 || tx_a !== 1'b1) begin
      n_fail++; $display("FAIL hold_end: busy %b line %b, expected 0 1", busy_a, tx_a);
    end
  endtask

  task automatic test_full_pop_same_edge();
    logic [7:0] vec [6];
    vec = '{8'hC3, 8'h0F, 8'hF0, 8'h81, 8'h7E, 8'h3C};
    wait_idle(0);
    exp_q = {8'hC3, 8'h0F, 8'hF0, 8'h81, 8'h7E, 8'h3C};
    fork
      begin
        valid_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
          data_a = vec[i];
          tick();
        end
        data_a = vec[5];
        n_tests++;
        if (ready_a !== 1'b0) begin
          n_fail++; $display("FAIL full_ready: got %b, expected 0", ready_a);
        end
        repeat (36) tick();
        n_tests++;
        if (ready_a !== 1'b0) begin
          n_fail++; $display("FAIL full_before_pop: got %b, expected 0", ready_a);
        end
        tick();
        n_tests++;
        if (ready_a !== 1'b1) begin
          n_fail++; $display("FAIL pop_edge_refused: ready %b, expected 1", ready_a);
        end
        tick();
        valid_a = 1'b0;
        n_tests++;
        if (ready_a !== 1'b0) begin
          n_fail++; $display("FAIL accepted_next_edge: ready %b, expected 0", ready_a);
        end
      end
      rx_check(0, 1, 6, "fullpop");
    join
    tick();
    n_tests++;
    if (busy_a !== 1'b0) begin
      n_fail++; $display("FAIL fullpop_busy_end: got %b, expected 0", busy_a);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit stayed;
    wait_idle(0);
    push_byte(0, 8'h00);
    push_byte(0, 8'h81);
    repeat (10) tick();
    n_tests++;
    if (tx_a !== 1'b0 || dbg_a.state !== TX_DATA) begin
      n_fail++; $display("FAIL midframe_pre: line %b state %0d, expected 0 2", tx_a, dbg_a.state);
    end
    #2 nrst = 1'b0;
    #1;
    n_tests++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_async: line %b busy %b ready %b, expected 1 0 1", tx_a, busy_a, ready_a);
    end
    @(posedge clk);
    #3 nrst = 1'b1;
    stayed = 1'b1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (tx_a !== 1'b1 || busy_a !== 1'b0) stayed = 1'b0;
    end
    n_tests++;
    if (!stayed) begin
      n_fail++; $display("FAIL midframe_no_resume: line/busy changed after release, expected 1/0");
    end
  endtask

  task automatic test_stop_bits2();
    wait_idle(1);
    exp_q = {8'h90, 8'h3C, 8'h7F};
    fork
      begin
        push_byte(1, 8'h90);
        push_byte(1, 8'h3C);
        push_byte(1, 8'h7F);
      end
      rx_check(1, 2, 3, "stop2");
    join
    tick();
    n_tests++;
    if (busy_b !== 1'b0 || tx_b !== 1'b1) begin
      n_fail++; $display("FAIL stop2_end: busy %b line %b, expected 0 1", busy_b, tx_b);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_hold_valid();
    test_full_pop_same_edge();
    test_reset_mid_frame();
    test_stop_bits2();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
